// File: rtl/fp32_min_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp32_min_scan_ctrl_if : stream-in / result-out bundle of the min-scan ctrl  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface fp32_min_scan_ctrl_if #(
  parameter int IDX_W = 16
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_min;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_idx, out_count, out_ovf, busy
  );

  modport slave (
    input  start, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_idx, out_count, out_ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/fp32_min_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp32_min_scan_ctrl : running fp32 minimum/position over a framed stream     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

// Sign/magnitude field ordering; -0 sorts below +0, NaN/Inf are plain bit patterns.
module fp32_lessthan (
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  output logic             lt
);
  always_comb begin
    lt = 1'b0;
    if (a[31] != b[31])
      lt = a[31];
    else if (a[31])
      lt = (a[30:0] > b[30:0]);
    else
      lt = (a[30:0] < b[30:0]);
  end
endmodule

module fp32_min_scan_ctrl #(
  parameter int IDX_W = 16
) (
  input wire logic             clk,
  input wire logic             rst,
  fp32_min_scan_ctrl_if.slave  bus
);
  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_SCAN  = 2'd1;
  localparam logic [1:0]       S_DONE  = 2'd2;
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic [31:0]      cur_min;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] cnt;
  logic             ovf;

  logic [31:0]      res_min;
  logic [IDX_W-1:0] res_idx;
  logic [IDX_W-1:0] res_count;
  logic             res_ovf;

  logic             beat;
  logic             lt;
  logic             first;
  logic             sat;
  logic [31:0]      min_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] cnt_nxt;
  logic             ovf_nxt;

  fp32_lessthan u_lt (
    .a  (bus.in_data),
    .b  (cur_min),
    .lt (lt)
  );

  assign beat  = bus.in_valid & bus.in_ready;
  assign first = (cnt == '0);
  assign sat   = (cnt == CNT_MAX);

  // Once the counter has saturated, positions are no longer representable,
  // so the value keeps tracking but the index is frozen.
  always_comb begin
    min_nxt = cur_min;
    idx_nxt = cur_idx;
    if (first || lt)
      min_nxt = bus.in_data;
    if (first || (lt && !ovf))
      idx_nxt = cnt;
    cnt_nxt = sat ? cnt : cnt + 1'b1;
    ovf_nxt = ovf | sat;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start)              state_nxt = S_SCAN;
      S_SCAN:  if (beat && bus.in_last)    state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)          state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_SCAN);
    bus.out_valid = (state == S_DONE);
    bus.busy      = (state == S_SCAN) || (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_min   <= '0;
      cur_idx   <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      res_min   <= '0;
      res_idx   <= '0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else if ((state == S_IDLE) && bus.start) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      cur_min <= min_nxt;
      cur_idx <= idx_nxt;
      cnt     <= cnt_nxt;
      ovf     <= ovf_nxt;
      if (bus.in_last) begin
        res_min   <= min_nxt;
        res_idx   <= idx_nxt;
        res_count <= cnt_nxt;
        res_ovf   <= ovf_nxt;
      end
    end
  end

  assign bus.out_min   = res_min;
  assign bus.out_idx   = res_idx;
  assign bus.out_count = res_count;
  assign bus.out_ovf   = res_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fp32_min_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp32_min_scan_ctrl : directed + randomized frames vs. an ordering model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_fp32_min_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_min_scan_ctrl_if #(.IDX_W(16)) bus  ();
  fp32_min_scan_ctrl_if #(.IDX_W(2))  sbus ();

  fp32_min_scan_ctrl #(.IDX_W(16)) dut       (.clk(clk), .rst(rst), .bus(bus));
  fp32_min_scan_ctrl #(.IDX_W(2))  dut_small (.clk(clk), .rst(rst), .bus(sbus));

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] frame_q [$];
  logic [31:0] pool [0:7] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                              32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Total order of fp32 bit patterns as signed integers: negatives map below -0 -> -1.
  function automatic longint fkey(input logic [31:0] w);
    longint m;
    m = 0;
    m[30:0] = w[30:0];
    return w[31] ? (-m - 1) : m;
  endfunction

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 1) == 1) return pool[$urandom_range(0, 7)];
    return $urandom();
  endfunction

  // Value = global minimum; index = earliest minimum among the positions the
  // counter can still name; count saturates at 2^W-1; overflow past that.
  task automatic model(input int idx_w, output logic [31:0] emin, output int eidx,
                       output int ecnt, output bit eovf);
    int n, maxc, lim;
    logic [31:0] pm;
    n    = frame_q.size();
    maxc = (1 << idx_w) - 1;
    emin = frame_q[0];
    for (int k = 1; k < n; k++)
      if (fkey(frame_q[k]) < fkey(emin)) emin = frame_q[k];
    lim  = (n - 1 < maxc) ? n - 1 : maxc;
    pm   = frame_q[0];
    eidx = 0;
    for (int k = 1; k <= lim; k++)
      if (fkey(frame_q[k]) < fkey(pm)) begin
        pm   = frame_q[k];
        eidx = k;
      end
    ecnt = (n < maxc) ? n : maxc;
    eovf = (n > maxc);
  endtask

  task automatic run_frame(input int gap_max, input int hold, input bit junk_with_start);
    logic [31:0] emin;
    int eidx, ecnt;
    bit eovf, rdy, ok;
    model(16, emin, eidx, ecnt, eovf);
    check("idle_in_ready", bus.in_ready, 0);
    bus.start = 1'b1;
    if (junk_with_start) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFF800000;
      bus.in_last  = 1'b1;
    end
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int k = 0; k < frame_q.size(); k++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = frame_q[k];
      bus.in_last  = (k == frame_q.size() - 1);
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk); rdy = bus.in_ready;
        @(posedge clk); #1;
        ok = rdy;
      end
      if (!ok) check("beat_accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    @(negedge clk);
    check("out_valid_latency", bus.out_valid, 1);
    check("in_ready_done", bus.in_ready, 0);
    check("out_min", bus.out_min, emin);
    check("out_idx", bus.out_idx, eidx);
    check("out_count", bus.out_count, ecnt);
    check("out_ovf", bus.out_ovf, eovf);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_min", bus.out_min, emin);
      check("hold_idx", bus.out_idx, eidx);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", bus.out_valid, 0);
    check("busy_drop", bus.busy, 0);
    check("kept_min", bus.out_min, emin);
  endtask

  initial begin
    logic [31:0] emin;
    int eidx, ecnt, n;
    bit eovf;
    rst = 1'b1;
    bus.start = 0;  bus.in_valid = 0;  bus.in_data = 0;  bus.in_last = 0;  bus.out_ready = 0;
    sbus.start = 0; sbus.in_valid = 0; sbus.in_data = 0; sbus.in_last = 0; sbus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_min", bus.out_min, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_small_busy", sbus.busy, 0);

    frame_q = '{32'h3F800000, 32'hC0000000, 32'h3F000000};
    run_frame(0, 1, 0);
    frame_q = '{32'h40400000, 32'h3F000000, 32'h3F000000, 32'h40000000};
    run_frame(0, 0, 0);
    frame_q = '{32'h00000000, 32'h80000000};
    run_frame(0, 0, 0);
    frame_q = '{32'h40400000};
    run_frame(0, 0, 0);
    frame_q = '{32'h41000000, 32'h40000000};
    run_frame(0, 0, 1);
    frame_q = '{32'h3F800000, 32'h40800000, 32'hBF000000, 32'h40000000, 32'hBF000000};
    run_frame(3, 5, 0);

    // Reset in the middle of a frame; the dropped beats would otherwise win.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hFF000000;
    @(posedge clk); #1;
    bus.in_data = 32'hFE000000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_min", bus.out_min, 0);
    frame_q = '{32'h40A00000, 32'h40E00000, 32'h40C00000};
    run_frame(1, 0, 0);

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 10);
      frame_q.delete();
      for (int k = 0; k < n; k++) frame_q.push_back(rand_word());
      run_frame(3, $urandom_range(0, 3), 0);
    end

    // Narrow counter: overflow, frozen index, start ignored in SCAN and DONE.
    frame_q = '{32'h40A00000, 32'h40400000, 32'h3F800000, 32'h40000000, 32'hBF800000};
    model(2, emin, eidx, ecnt, eovf);
    sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sbus.in_valid = 1'b1;
      sbus.in_data  = frame_q[k];
      sbus.in_last  = (k == 4);
      sbus.start    = (k == 1);
      @(posedge clk); #1;
    end
    sbus.in_valid = 1'b0; sbus.in_last = 1'b0; sbus.start = 1'b0;
    @(negedge clk);
    check("ovf_out_valid", sbus.out_valid, 1);
    check("ovf_out_min", sbus.out_min, emin);
    check("ovf_out_idx", sbus.out_idx, eidx);
    check("ovf_out_count", sbus.out_count, ecnt);
    check("ovf_flag", sbus.out_ovf, eovf);
    @(posedge clk); #1;
    sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    @(negedge clk);
    check("done_start_ignored", sbus.out_valid, 1);
    check("done_count_stable", sbus.out_count, ecnt);
    sbus.out_ready = 1'b1;
    @(posedge clk); #1;
    sbus.out_ready = 1'b0;
    @(negedge clk);
    check("small_out_valid_drop", sbus.out_valid, 0);

    frame_q = '{32'h40000000, 32'h3F800000};
    model(2, emin, eidx, ecnt, eovf);
    sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sbus.in_valid = 1'b1;
      sbus.in_data  = frame_q[k];
      sbus.in_last  = (k == 1);
      @(posedge clk); #1;
    end
    sbus.in_valid = 1'b0; sbus.in_last = 1'b0;
    @(negedge clk);
    check("small2_out_valid", sbus.out_valid, 1);
    check("small2_ovf_cleared", sbus.out_ovf, eovf);
    check("small2_count", sbus.out_count, ecnt);
    check("small2_idx", sbus.out_idx, eidx);
    sbus.out_ready = 1'b1;
    @(posedge clk); #1;
    sbus.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
